// File: rtl/time_counter.sv
// time_counter: BCD HH:MM time-of-day counter with minute advance and range-checked load.
//   clock                    rising-edge system clock
//   reset                    asynchronous active-low reset (deassertion synchronised internally)
//   one_minute               single-cycle advance strobe
//   load_new_c               single-cycle load request for new_current_time_*
//   new_current_time_*       BCD digits to load (ms_hr, ls_hr, ms_min, ls_min)
//   current_time_*           registered BCD time digits
//   day_rollover             one-cycle pulse aligned with the (MAX_HOURS-1):59 -> 00:00 update
//   load_error               one-cycle pulse when a load request is rejected
module time_counter #(
    parameter int MAX_HOURS = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       day_rollover,
    output logic       load_error
);
    // ERROR is the only state with bit 1 set, so load_error is a plain flop output
    typedef enum logic [1:0] {IDLE = 2'b00, UPDATE = 2'b01, ERROR = 2'b10} state_t;
    localparam logic [7:0] HR_LAST = 8'(MAX_HOURS - 1);
    state_t     state_q, state_d;
    logic       ready_q;
    logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
    logic [3:0] ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
    logic       roll_q, roll_d;
    logic [7:0] hr_val, new_hr_val;
    logic       load_ok, c_min, c_hr, c_day;

    assign hr_val     = {4'd0, ms_hr_q} * 8'd10 + {4'd0, ls_hr_q};
    assign new_hr_val = {4'd0, new_current_time_ms_hr} * 8'd10 + {4'd0, new_current_time_ls_hr};
    assign load_ok    = new_current_time_ms_hr <= 4'd9 && new_current_time_ls_hr <= 4'd9 &&
                        new_current_time_ms_min <= 4'd5 && new_current_time_ls_min <= 4'd9 &&
                        new_hr_val <= HR_LAST;
    // carry chain: minute units -> minute tens -> hour -> day
    assign c_min = ls_min_q == 4'd9;
    assign c_hr  = c_min && ms_min_q == 4'd5;
    assign c_day = c_hr && hr_val == HR_LAST;

    always_comb begin
        state_d  = IDLE;
        ms_hr_d  = ms_hr_q;
        ls_hr_d  = ls_hr_q;
        ms_min_d = ms_min_q;
        ls_min_d = ls_min_q;
        roll_d   = 1'b0;
        if (ready_q && load_new_c) begin
            state_d = load_ok ? UPDATE : ERROR;
            if (load_ok) begin
                ms_hr_d  = new_current_time_ms_hr;
                ls_hr_d  = new_current_time_ls_hr;
                ms_min_d = new_current_time_ms_min;
                ls_min_d = new_current_time_ls_min;
            end
        end else if (ready_q && one_minute) begin
            state_d  = UPDATE;
            ls_min_d = c_min ? 4'd0 : ls_min_q + 4'd1;
            ms_min_d = c_hr ? 4'd0 : c_min ? ms_min_q + 4'd1 : ms_min_q;
            ls_hr_d  = (c_day || (c_hr && ls_hr_q == 4'd9)) ? 4'd0 : c_hr ? ls_hr_q + 4'd1 : ls_hr_q;
            ms_hr_d  = c_day ? 4'd0 : (c_hr && ls_hr_q == 4'd9) ? ms_hr_q + 4'd1 : ms_hr_q;
            roll_d   = c_day;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            ms_hr_q  <= 4'd0;
            ls_hr_q  <= 4'd0;
            ms_min_q <= 4'd0;
            ls_min_q <= 4'd0;
            roll_q   <= 1'b0;
        end else begin
            // strobes are ignored on the first edge after reset release
            state_q  <= state_d;
            ready_q  <= 1'b1;
            ms_hr_q  <= ms_hr_d;
            ls_hr_q  <= ls_hr_d;
            ms_min_q <= ms_min_d;
            ls_min_q <= ls_min_d;
            roll_q   <= roll_d;
        end
    end

    assign current_time_ms_hr  = ms_hr_q;
    assign current_time_ls_hr  = ls_hr_q;
    assign current_time_ms_min = ms_min_q;
    assign current_time_ls_min = ls_min_q;
    assign day_rollover        = roll_q;
    assign load_error          = state_q[1];

    a_digits_legal: assert property (@(posedge clock) disable iff (!reset)
        ls_min_q <= 4'd9 && ms_min_q <= 4'd5 && ls_hr_q <= 4'd9 && hr_val <= HR_LAST);
    a_roll_zero: assert property (@(posedge clock) disable iff (!reset)
        day_rollover |-> {ms_hr_q, ls_hr_q, ms_min_q, ls_min_q} == 16'h0000);
    a_pulse_excl: assert property (@(posedge clock) disable iff (!reset)
        !(day_rollover && load_error));
endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- BCD time-of-day counter directly downstream of the timebase stage.
- Consumes the single-cycle one_minute strobe and advances a 4-digit HH:MM time.
- Supports a synchronous load of a new current time from the alarm controller, with range checking.
- Feeds the display driver and the alarm comparator.

Parameters:
MAX_HOURS, 24, hour modulus; hours count 0..MAX_HOURS-1; legal values 2..24.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
one_minute  input  1  single-cycle advance strobe from the timebase (fastwatch already folded in upstream)
load_new_c  input  1  single-cycle request to load new_current_time_*
new_current_time_ms_hr  input  4  BCD tens of hours to load
new_current_time_ls_hr  input  4  BCD units of hours to load
new_current_time_ms_min  input  4  BCD tens of minutes to load
new_current_time_ls_min  input  4  BCD units of minutes to load
current_time_ms_hr  output  4  BCD tens of hours
current_time_ls_hr  output  4  BCD units of hours
current_time_ms_min  output  4  BCD tens of minutes
current_time_ls_min  output  4  BCD units of minutes
day_rollover  output  1  one-cycle pulse when time wraps from (MAX_HOURS-1):59 to 00:00
load_error  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset==0, asynchronous):
  - all four time digits = 0, i.e. 00:00.
  - day_rollover = 0, load_error = 0.
- Reset deassertion is synchronised internally; the first advance or load is accepted on the second rising clock edge after reset goes high.
- Outputs:
  - All outputs are registered.
  - Time digits change on the same rising edge that samples one_minute==1 or load_new_c==1, and are visible the cycle after the strobe.
- Priority, evaluated at each rising edge: reset > load_new_c > one_minute > hold.
- Load validation (combinational on the new_current_time_* inputs):
  - Each digit must be valid BCD (<=9).
  - ms_min must be <=5.
  - Hour value ms_hr*10+ls_hr must be <= MAX_HOURS-1.
  - Valid load: all four digits are replaced in one edge; a one_minute arriving in the same cycle is discarded (not deferred).
  - Invalid load: time holds; load_error pulses for exactly one cycle; a simultaneous one_minute is also discarded.
- Advance on one_minute:
  - ls_min 0..9 increments; at 9 it wraps to 0 and carries into ms_min.
  - ms_min 0..5; at 5 with carry it wraps to 0 and carries into the hour.
  - Hour (two BCD digits treated as one value): increments; on a carry from (MAX_HOURS-1) it wraps to 00 and day_rollover pulses one cycle, aligned with the 00:00 update.
  - ls_hr at 9 with carry becomes 0 and ms_hr increments.
- Internal state: a per-digit carry chain feeding a 3-state control FSM.
  - IDLE: waiting for a strobe.
  - UPDATE: one cycle, while digits are written.
  - ERROR: one cycle, while load_error is driven.
  - Both UPDATE and ERROR return to IDLE.
  - A strobe arriving while in UPDATE or ERROR is processed from that state, with the same priority rules.
  - Back-to-back one_minute strobes on consecutive cycles each advance the time by one minute; none are dropped.
- Reset mid-operation: all state is cleared immediately, any in-flight pulse output is forced to 0, and the FSM returns to IDLE.
- Digits never hold a non-BCD value or an out-of-range time under any input sequence.
- Assertions required in RTL:
  - Digits are legal after every edge.
  - day_rollover implies the time is 00:00 in the same cycle.
  - load_error and day_rollover are never high together.

Test Plan:
- Reset low for 3 cycles, then high -> all digits 0, day_rollover=0, load_error=0 throughout; first strobe accepted on the 2nd edge after reset rises.
- Load 12:59, then one one_minute strobe -> outputs 12:59, then 13:00 one cycle after the strobe; day_rollover stays 0.
- Load 23:59, then one_minute -> 00:00 with a single-cycle day_rollover=1 aligned to the update; with MAX_HOURS=12, load 11:59 + one_minute -> 00:00 with rollover.
- Load 24:00, then 09:60, then 0A:00 (hex A in ls digit) -> each holds the previous time and pulses load_error for one cycle.
- load_new_c with 07:30 and one_minute asserted in the same cycle -> 07:30 (not 07:31); 5 consecutive one_minute strobes from 07:30 -> 07:35.
- Start at 10:58, issue one_minute, then pull reset low in the middle of the next one_minute cycle -> outputs go to 00:00 immediately with no rollover or error pulse.
